// File: rtl/mealy_seq_detector.sv
// Serial Mealy pattern detector with a saturating match counter.
// Tracks how many leading bits of PATTERN are currently matched, using a
// next-state table derived from PATTERN at elaboration time (KMP failure
// function), so no pattern comparison logic exists at run time.
module mealy_seq_detector #(
  parameter int                    PATTERN_LEN = 4,
  parameter logic [PATTERN_LEN-1:0] PATTERN    = 4'b1011,
  parameter bit                    OVERLAP     = 1'b1,
  parameter int                    COUNT_W     = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               en,
  input  logic               control,
  input  logic               clear_count,
  output logic               match,
  output logic               match_q,
  output logic [COUNT_W-1:0] match_count,
  output logic [4:0]         state_dbg
);

  // State = number of pattern bits matched so far (0..PATTERN_LEN-1). The
  // count of states depends on PATTERN_LEN, so a numeric type is used instead
  // of a named enumeration.
  typedef logic [4:0] state_t;

  localparam state_t LAST_S = state_t'(PATTERN_LEN - 1);

  // Longest pattern prefix that is a suffix of (first s pattern bits, then b),
  // capped at PATTERN_LEN-1. On a final-bit match this yields the longest
  // proper border of PATTERN; on any other match it yields s+1.
  function automatic state_t kmp_next(input int s, input int b);
    logic [15:0] seq;
    int          best;
    logic        ok;
    seq = '0;
    for (int j = 0; j < 16; j++) begin
      if (j < s) seq[j] = PATTERN[PATTERN_LEN-1-j];
    end
    seq[s] = b[0];
    best = 0;
    for (int k = 1; k <= 16; k++) begin
      if (k <= s + 1 && k <= PATTERN_LEN - 1) begin
        ok = 1'b1;
        for (int i = 0; i < 16; i++) begin
          if (i < k) begin
            if (PATTERN[PATTERN_LEN-1-i] != seq[s+1-k+i]) ok = 1'b0;
          end
        end
        if (ok) best = k;
      end
    end
    return state_t'(best);
  endfunction

  // Constant next-state table, indexed by [state][incoming bit]. Rows beyond
  // the last legal state are unreachable and tied to zero.
  state_t next_tab [32][2];

  for (genvar gs = 0; gs < 32; gs++) begin : g_row
    for (genvar gb = 0; gb < 2; gb++) begin : g_col
      if (gs < PATTERN_LEN) begin : g_live
        localparam state_t NXT = kmp_next(gs, gb);
        assign next_tab[gs][gb] = NXT;
      end else begin : g_pad
        assign next_tab[gs][gb] = '0;
      end
    end
  end

  state_t state;
  state_t state_nxt;

  // State register: advances only on enabled samples.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= '0;
    end else if (en) begin
      state <= state_nxt;
    end
  end

  // Next state and Mealy match output from the current state and input bit.
  // NOTE: every signal gets a default at the top so no path leaves one
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_nxt = state;
    match     = en & ~reset & (state == LAST_S) & (control == PATTERN[0]);
    if (en) begin
      state_nxt = next_tab[state][control];
      if (match && !OVERLAP) state_nxt = '0;
    end
  end

  // Registered match flag and saturating match counter; clear beats a match.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      match_q     <= 1'b0;
      match_count <= '0;
    end else begin
      match_q <= match;
      if (clear_count) begin
        match_count <= '0;
      end else if (match && (match_count != '1)) begin
        match_count <= match_count + COUNT_W'(1);
      end
    end
  end

  assign state_dbg = state;

endmodule

// File: tb/tb_mealy_seq_detector.sv
// Self-checking bench for mealy_seq_detector. Three instances share one
// stimulus stream: overlapping (count width 8), non-overlapping (width 8) and
// non-overlapping with a 2-bit counter. A window/suffix model of the pattern
// rules predicts every output each cycle; directed sequences pin the model
// with hand-computed values.
module tb_mealy_seq_detector;

  localparam int         L   = 4;
  localparam logic [3:0] PAT = 4'b1011;

  logic       clk = 1'b0;
  logic       reset;
  logic       en;
  logic       control;
  logic       clear_count;

  logic       dm [3];
  logic       dmq [3];
  logic [4:0] dst [3];
  logic [7:0] dcnt0, dcnt1;
  logic [1:0] dcnt2;

  int n_checks = 0;
  int n_fail   = 0;
  bit cmp_on   = 1'b0;
  logic cap_m [3];

  always #5 clk = ~clk;

  mealy_seq_detector #(.PATTERN_LEN(L), .PATTERN(PAT), .OVERLAP(1'b1), .COUNT_W(8)) u_ov (
    .clk(clk), .reset(reset), .en(en), .control(control), .clear_count(clear_count),
    .match(dm[0]), .match_q(dmq[0]), .match_count(dcnt0), .state_dbg(dst[0]));

  mealy_seq_detector #(.PATTERN_LEN(L), .PATTERN(PAT), .OVERLAP(1'b0), .COUNT_W(8)) u_no (
    .clk(clk), .reset(reset), .en(en), .control(control), .clear_count(clear_count),
    .match(dm[1]), .match_q(dmq[1]), .match_count(dcnt1), .state_dbg(dst[1]));

  mealy_seq_detector #(.PATTERN_LEN(L), .PATTERN(PAT), .OVERLAP(1'b0), .COUNT_W(2)) u_sat (
    .clk(clk), .reset(reset), .en(en), .control(control), .clear_count(clear_count),
    .match(dm[2]), .match_q(dmq[2]), .match_count(dcnt2), .state_dbg(dst[2]));

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Per instance: the accepted bits since reset (or since the last match when
  // overlap is off), newest bit in bit 0, and how many are valid.
  logic [15:0] m_hist [3];
  int          m_len  [3];
  int          m_cnt  [3];
  bit          m_mq   [3];

  function automatic bit overlap_of(input int i);
    return (i == 0);
  endfunction

  function automatic int cnt_max(input int i);
    return (i == 2) ? 3 : 255;
  endfunction

  // True when the last L accepted bits followed by b spell the pattern.
  function automatic bit window_hit(input logic [15:0] h, input int len, input logic b);
    logic [15:0] seq;
    seq = {h[14:0], b};
    return (len + 1 >= L) && (seq[3:0] == PAT);
  endfunction

  // Longest pattern prefix (shorter than the pattern) that ends the history.
  function automatic int suffix_state(input logic [15:0] h, input int len);
    int best;
    best = 0;
    for (int k = 1; k < L; k++) begin
      if (k <= len && ((int'(h) & ((1 << k) - 1)) == (int'(PAT) >> (L - k)))) best = k;
    end
    return best;
  endfunction

  function automatic bit exp_match(input int i);
    return en && !reset && window_hit(m_hist[i], m_len[i], control);
  endfunction

  function automatic int act_cnt(input int i);
    case (i)
      0:       return int'(dcnt0);
      1:       return int'(dcnt1);
      default: return int'(dcnt2);
    endcase
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 3; i++) begin
        m_hist[i] <= '0;
        m_len[i]  <= 0;
        m_cnt[i]  <= 0;
        m_mq[i]   <= 1'b0;
      end
    end else begin
      for (int i = 0; i < 3; i++) begin
        m_mq[i] <= en && window_hit(m_hist[i], m_len[i], control);
        if (clear_count) begin
          m_cnt[i] <= 0;
        end else if (en && window_hit(m_hist[i], m_len[i], control) && m_cnt[i] < cnt_max(i)) begin
          m_cnt[i] <= m_cnt[i] + 1;
        end
        if (en) begin
          if (window_hit(m_hist[i], m_len[i], control) && !overlap_of(i)) begin
            m_hist[i] <= '0;
            m_len[i]  <= 0;
          end else begin
            m_hist[i] <= {m_hist[i][14:0], control};
            m_len[i]  <= (m_len[i] < 16) ? m_len[i] + 1 : 16;
          end
        end
      end
    end
  end

  // Cycle-by-cycle comparison, mid-cycle where inputs and outputs are settled.
  always @(negedge clk) begin
    if (cmp_on) begin
      for (int i = 0; i < 3; i++) begin
        check($sformatf("match[%0d]", i), int'(dm[i]), int'(exp_match(i)));
        check($sformatf("match_q[%0d]", i), int'(dmq[i]), int'(m_mq[i]));
        check($sformatf("state_dbg[%0d]", i), int'(dst[i]), suffix_state(m_hist[i], m_len[i]));
        check($sformatf("match_count[%0d]", i), act_cnt(i), m_cnt[i]);
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  // Drive one cycle of inputs 2 ns after a rising edge, record match mid-cycle,
  // and return 2 ns after the consuming edge.
  task automatic step(input logic e, input logic b, input logic c);
    en = e; control = b; clear_count = c;
    @(negedge clk);
    for (int i = 0; i < 3; i++) cap_m[i] = dm[i];
    @(posedge clk);
    #2;
  endtask

  // 20 ns asynchronous reset pulse starting mid-cycle.
  task automatic pulse_reset();
    reset = 1'b1;
    #1;
    check("reset_state_immediate", int'(dst[0]), 0);
    check("reset_count_immediate", int'(dcnt0), 0);
    #19;
    reset = 1'b0;
  endtask

  logic [6:0] s7;
  logic [6:0] exp_ov, exp_no;
  logic [4:0] s5;
  logic [3:0] exp_st3;

  initial begin
    reset = 1'b1; en = 1'b0; control = 1'b0; clear_count = 1'b0;
    @(posedge clk); #2;
    cmp_on = 1'b1;
    en = 1'b1; control = 1'b1;
    #3;
    check("reset_match_forced_low", int'(dm[0]), 0);
    check("reset_state", int'(dst[0]), 0);
    check("reset_match_q", int'(dmq[0]), 0);
    check("reset_count", int'(dcnt0), 0);
    @(posedge clk); #2;
    reset = 1'b0;

    // Stream 1,0,1,1,0,1,1 into overlapping and non-overlapping instances.
    s7 = 7'b1011011; exp_ov = 7'b0001001; exp_no = 7'b0001000;
    for (int k = 0; k < 7; k++) begin
      step(1'b1, s7[6-k], 1'b0);
      check($sformatf("ov_match_bit%0d", k + 1), int'(cap_m[0]), int'(exp_ov[6-k]));
      check($sformatf("no_match_bit%0d", k + 1), int'(cap_m[1]), int'(exp_no[6-k]));
      if (k == 3) check("ov_match_q_after_bit4", int'(dmq[0]), 1);
    end
    check("ov_match_q_after_bit7", int'(dmq[0]), 1);
    check("ov_count", int'(dcnt0), 2);
    check("no_count", int'(dcnt1), 1);
    check("no_state_after_bit7", int'(dst[1]), 1);

    // Mismatch recovery: 1,1,0,1,1.
    pulse_reset();
    s5 = 5'b11011; exp_st3 = 4'b0000;
    for (int k = 0; k < 5; k++) begin
      step(1'b1, s5[4-k], 1'b0);
      case (k)
        0: check("recov_state1", int'(dst[0]), 1);
        1: check("recov_state2", int'(dst[0]), 1);
        2: check("recov_state3", int'(dst[0]), 2);
        3: check("recov_state4", int'(dst[0]), 3);
        default: check("recov_match_bit5", int'(cap_m[0]), 1);
      endcase
    end

    // Enable gating: 1,0,1 then three disabled clocks with control=1.
    pulse_reset();
    step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    for (int k = 0; k < 3; k++) begin
      step(1'b0, 1'b1, 1'b0);
      check("gated_no_match", int'(cap_m[0]), 0);
      check("gated_state_hold", int'(dst[0]), 3);
    end
    step(1'b1, 1'b1, 1'b0);
    check("resumed_match", int'(cap_m[0]), 1);
    check("resumed_count", int'(dcnt0), 1);

    // Reset mid-pattern discards progress.
    step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    check("pre_reset_state", int'(dst[0]), 3);
    pulse_reset();
    step(1'b1, 1'b1, 1'b0);
    check("post_reset_no_match", int'(cap_m[0]), 0);
    check("post_reset_state", int'(dst[0]), 1);

    // Saturation of the 2-bit counter, then clear against a coincident match.
    pulse_reset();
    for (int r = 0; r < 5; r++) begin
      step(1'b1, 1'b1, 1'b0);
      step(1'b1, 1'b0, 1'b0);
      step(1'b1, 1'b1, 1'b0);
      step(1'b1, 1'b1, 1'b0);
      check($sformatf("sat_count_rep%0d", r + 1), int'(dcnt2), (r < 3) ? r + 1 : 3);
    end
    step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b1);
    check("clear_coincident_match", int'(cap_m[2]), 1);
    check("clear_wins", int'(dcnt2), 0);
    check("clear_keeps_state_ov", int'(dst[0]), 1);
    clear_count = 1'b0;

    // Randomized traffic checked by the model every cycle.
    for (int n = 0; n < 2000; n++) begin
      if ($urandom_range(0, 199) == 0) begin
        pulse_reset();
      end else begin
        logic e, b, c;
        e = ($urandom_range(0, 3) != 0);
        b = 1'($urandom_range(0, 1));
        c = e && ($urandom_range(0, 31) == 0);
        step(e, b, c);
      end
    end

    cmp_on = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
